uart_rx_buffered: RTL
=====================

# uart_rx_buffered

Receive path of the system UART, sitting directly downstream of the simulation UART model (or the board pin) that drives `uart_rx_i`. It synchronises the asynchronous serial line, decodes 8N1 frames at a fixed clocks-per-bit ratio, and buffers received bytes in a small FIFO. Software reads the FIFO through a valid/ready pop port, which also drives the RX interrupt.

## Interface
Parameters:
- `ClockFrequency`, 125_000_000, system clock in Hz
- `BaudRate`, 15_625_000, line rate; `ClksPerBit = ClockFrequency/BaudRate` must be an even integer ≥ 4 (elaboration error otherwise)
- `FifoDepth`, 8, byte entries; power of two, ≥ 2

Ports:
- `clk_i`  in  1  system clock; one clock domain
- `rst_ni`  in  1  reset, asynchronous, active-low
- `rx_i`  in  1  serial line, asynchronous, idle high
- `rdata_o`  out  8  head-of-FIFO byte; 0 when empty
- `rvalid_o`  out  1  FIFO non-empty
- `rready_i`  in  1  pop; a byte is consumed when `rvalid_o && rready_i` at a clock edge
- `level_o`  out  $clog2(FifoDepth+1)  current occupancy
- `overflow_o`  out  1  sticky: a byte was dropped because the FIFO was full
- `frame_err_o`  out  1  sticky: stop bit sampled low
- `clr_err_i`  in  1  clears both sticky flags
- `irq_o`  out  1  equals `rvalid_o`

## Operation
- Line synchroniser: two flops, both reset to 1. A third flop `rx_prev` (reset 1) provides falling-edge detect.
- FSM states: IDLE, START, DATA, STOP. Down-counter `cnt` (width $clog2(ClksPerBit)), bit index `idx` (3 bits), shift register `sr` (8 bits, LSB first).
- IDLE: on synced falling edge -> START, `cnt = ClksPerBit/2 - 1`.
- START: when `cnt == 0`, sample. Low -> DATA, `cnt = ClksPerBit - 1`, `idx = 0`. High -> IDLE (glitch rejected, no flag).
- DATA: when `cnt == 0`, shift the sample into `sr[7]` (right shift) and reload `cnt`. After `idx == 7` -> STOP.
- STOP: when `cnt == 0`, sample. High -> push `sr` and go to IDLE. Low -> set `frame_err_o`, discard the byte, go to IDLE.
- After any STOP, a new frame needs a fresh falling edge. A held-low break therefore yields exactly one frame error.
- Push while full without a same-cycle pop: byte dropped, `overflow_o` set. Push and pop in the same cycle while full: both succeed, level unchanged, no overflow. Push and pop in the same cycle while empty: push only.
- `clr_err_i` has priority below a same-cycle set, so a set in that cycle wins.
- Reset at any point: FSM to IDLE, FIFO emptied, flags cleared. A reset mid-frame loses the partial byte. Because the synchroniser resets high, no spurious start follows reset.

## Timing
- Reset values: `rdata_o = 0`, `rvalid_o = 0`, `level_o = 0`, `overflow_o = 0`, `frame_err_o = 0`, `irq_o = 0`.
- `rx_i` fall in cycle 0 -> START entered in cycle 3. Sample points at cycles 3 + ClksPerBit/2 - 1 + k·ClksPerBit, for k = 0 (start), 1–8 (data), 9 (stop).
- `ClksPerBit = 8`: start sampled at cycle 6, data at 14..70, stop at 78. `rvalid_o` rises in cycle 79.
- Pop takes effect at the clock edge. `rdata_o`/`rvalid_o` show the next entry the following cycle. No combinational path from `rready_i` to any output.
- Sustained throughput: one byte per 10·ClksPerBit cycles.

## Structure
- Shared package `uart_pkg`: `uart_rx_state_e` enum (IDLE, START, DATA, STOP) and `localparam`/function `clks_per_bit(ClockFrequency, BaudRate)`, so the TX side reuses them.
- One sub-module: `uart_byte_fifo` (synchronous FIFO, parameterised width/depth, push/pop/full/empty/level, async active-low reset). The frame decoder stays in the top module.

## Test plan
- Reset with `rx_i = 1`; hold for 100 cycles -> all outputs 0, FSM in IDLE.
- Send 0xA5 at ClksPerBit = 8, starting at cycle 0 -> `rvalid_o` rises at cycle 79 with `rdata_o = 0xA5`. Pop -> `rvalid_o = 0`, `level_o = 0`.
- Low glitch of 3 cycles on `rx_i` -> no byte received, no flag set, FSM back in IDLE.
- Frame 0x3C with stop bit low -> `frame_err_o = 1`, `level_o = 0`. `clr_err_i` pulse -> `frame_err_o = 0`.
- Send 9 bytes 0x00..0x08 with no pops (depth 8) -> `level_o = 8`, `overflow_o = 1`. Pops return 0x00..0x07 in order.
- Assert `rst_ni` low at cycle 40 of a frame -> outputs reset. The trailing bits of the interrupted frame produce no byte. The next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and the clocks-per-bit helper,
// reused by both the RX and TX paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_e;

  localparam int unsigned UartDataBits = 8;

  function automatic int unsigned clks_per_bit(input int unsigned clock_hz,
                                               input int unsigned baud);
    return clock_hz / baud;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous FIFO with occupancy count. A push while full is accepted only
// when a pop happens in the same cycle; the head reads as zero when empty.
module uart_byte_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW   = $clog2(Depth),
  localparam int unsigned LevelW = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [Width-1:0]  wdata_i,
  input  logic              pop_i,
  output logic [Width-1:0]  rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [LevelW-1:0] level_o
);

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [LevelW-1:0] count_q, count_d;
  logic              push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == LevelW'(Depth));
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];
  assign level_o = count_q;

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receive path: synchronises the line, decodes 8N1 frames at a fixed
// clocks-per-bit ratio and buffers bytes behind a valid/ready pop port.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned ClockFrequency = 125_000_000,
  parameter int unsigned BaudRate       = 15_625_000,
  parameter int unsigned FifoDepth      = 8,
  localparam int unsigned LevelW        = $clog2(FifoDepth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_i,
  output logic [7:0]        rdata_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [LevelW-1:0] level_o,
  output logic              overflow_o,
  output logic              frame_err_o,
  input  logic              clr_err_i,
  output logic              irq_o
);

  localparam int unsigned ClksPerBit = clks_per_bit(ClockFrequency, BaudRate);
  localparam int unsigned CntW       = $clog2(ClksPerBit);
  localparam logic [CntW-1:0] CntFull = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(ClksPerBit / 2 - 1);

  if (ClksPerBit < 4 || (ClksPerBit % 2) != 0 || (ClockFrequency % BaudRate) != 0)
  begin : g_bad_baud
    $error("ClockFrequency/BaudRate must be an even integer >= 4");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
    $error("FifoDepth must be a power of two >= 2");
  end

  logic [1:0]            rx_sync_q;
  logic                  rx_prev_q;
  logic                  rx_s, rx_fall;
  uart_rx_state_e        state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [UartDataBits-1:0] sr_q, sr_d;
  logic                  push, ferr_set, ovf_set, pop;
  logic                  overflow_q, overflow_d, frame_err_q, frame_err_d;
  logic                  fifo_full, fifo_empty;

  assign rx_s    = rx_sync_q[1];
  assign rx_fall = rx_prev_q && !rx_s;

  // Synchroniser and edge detector reset high so reset never looks like a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_sync_q <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      rx_sync_q <= {rx_sync_q[0], rx_i};
      rx_prev_q <= rx_s;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sr_d     = sr_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_fall) begin
          state_d = START;
          cnt_d   = CntHalf;
        end
      end
      START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx_s) begin
          state_d = DATA;
          cnt_d   = CntFull;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          sr_d  = {rx_s, sr_q[7:1]};
          cnt_d = CntFull;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          push     = rx_s;
          ferr_set = !rx_s;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
    end
  end

  assign pop     = rvalid_o && rready_i;
  assign ovf_set = push && fifo_full && !pop;

  // A set in the same cycle as a clear wins.
  always_comb begin
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;
    if (clr_err_i) begin
      overflow_d  = 1'b0;
      frame_err_d = 1'b0;
    end
    if (ovf_set)  overflow_d  = 1'b1;
    if (ferr_set) frame_err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  uart_byte_fifo #(
    .Width (UartDataBits),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (sr_q),
    .pop_i   (rready_i),
    .rdata_o (rdata_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  assign rvalid_o    = !fifo_empty;
  assign irq_o       = rvalid_o;
  assign overflow_o  = overflow_q;
  assign frame_err_o = frame_err_q;

endmodule
